// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
// Holds the FSM encoding, word geometry and the access-alignment rule.
package data_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BYTES  = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } stateT;

    // Loads must be word aligned; stores must use a lane pattern that fits the low address bits.
    function automatic logic isMisaligned(input logic write,
                                          input logic [1:0] lowAddr,
                                          input logic [BYTES-1:0] byteEn);
        logic ok;
        ok = 1'b0;
        if (!write) begin
            ok = (lowAddr == 2'b00);
        end else begin
            case (byteEn)
                4'b1111:          ok = (lowAddr == 2'b00);
                4'b0011, 4'b1100: ok = !lowAddr[0];
                4'b0001:          ok = (lowAddr == 2'd0);
                4'b0010:          ok = (lowAddr == 2'd1);
                4'b0100:          ok = (lowAddr == 2'd2);
                4'b1000:          ok = (lowAddr == 2'd3);
                default:          ok = 1'b0;
            endcase
        end
        return !ok;
    endfunction

endpackage

// File: rtl/data_mem_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered,
// clearable read port whose register doubles as the response data holder.
module data_mem_ram
    import data_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  writeEn,
    input  logic [BYTES-1:0]      byteEn,
    input  logic                  readEn,
    input  logic                  readClr,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clock) begin
        if (writeEn) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byteEn[b]) begin
                    mem[index][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Clear wins over read so a completing store or reset zeroes the response word.
    always_ff @(posedge clock) begin
        if (readClr) begin
            rdata <= '0;
        end else if (readEn) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: one request at a time, programmable wait states, pipeline stall.
// Optional alignment checking (resp_misaligned port) is enabled by defining DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BYTES-1:0]  req_byte_en,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              stall
`ifdef DATA_MEM_ALIGN_CHECK_EN
    ,
    output logic              resp_misaligned
`endif
);

    localparam logic [CNT_W-1:0] WAIT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    stateT                 state;
    stateT                 nextState;
    logic                  accept;
    logic [CNT_W-1:0]      waitCnt;
    logic                  reqWrite;
    logic [DEPTH_LOG2-1:0] reqIndex;
    logic [WORD_W-1:0]     reqWdata;
    logic [BYTES-1:0]      reqByteEn;
    logic                  accessBad;
    logic                  ramWe;
    logic                  ramRe;
    logic                  ramClr;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic reqMisaligned;
    logic unusedAddrBits;
    assign unusedAddrBits = ^req_addr[WORD_W-1:DEPTH_LOG2+2];
    assign accessBad      = reqMisaligned;
`else
    logic unusedAddrBits;
    assign unusedAddrBits = ^{req_addr[WORD_W-1:DEPTH_LOG2+2], req_addr[1:0]};
    assign accessBad      = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        stall      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    accept    = 1'b1;
                    nextState = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (waitCnt == '0) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                stall     = 1'b1;
                nextState = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Request fields are captured at the handshake so the pipeline may move its inputs on.
    always_ff @(posedge clock) begin
        if (reset) begin
            waitCnt   <= '0;
            reqWrite  <= 1'b0;
            reqIndex  <= '0;
            reqWdata  <= '0;
            reqByteEn <= '0;
        end else if (accept) begin
            waitCnt   <= WAIT_INIT;
            reqWrite  <= req_write;
            reqIndex  <= req_addr[DEPTH_LOG2+1:2];
            reqWdata  <= req_wdata;
            reqByteEn <= req_byte_en;
        end else if (state == WAIT && waitCnt != '0) begin
            waitCnt <= waitCnt - 1'b1;
        end
    end

`ifdef DATA_MEM_ALIGN_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            reqMisaligned   <= 1'b0;
            resp_misaligned <= 1'b0;
        end else begin
            if (accept) begin
                reqMisaligned <= isMisaligned(req_write, req_addr[1:0], req_byte_en);
            end
            if (state == ACCESS) begin
                resp_misaligned <= reqMisaligned;
            end
        end
    end
`endif

    // A reset landing on the ACCESS cycle still abandons the store.
    assign ramWe  = (state == ACCESS) && reqWrite && !accessBad && !reset;
    assign ramRe  = (state == ACCESS) && !reqWrite && !accessBad;
    assign ramClr = reset || ((state == ACCESS) && (reqWrite || accessBad));

    data_mem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) uRam (
        .clock  (clock),
        .writeEn(ramWe),
        .byteEn (reqByteEn),
        .readEn (ramRe),
        .readClr(ramClr),
        .index  (reqIndex),
        .wdata  (reqWdata),
        .rdata  (resp_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: driver pushes reference-model expectations,
// a negedge monitor pops and compares on every resp_valid.
module tb_data_mem_responder;

    localparam int DEPTH_LOG2 = 8;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam int WAIT_CYCLES = 0;
`else
    localparam int WAIT_CYCLES = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_byte_en = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        stall;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic        resp_misaligned;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
    } expT;

    expT         sb[$];
    logic [31:0] model [0:(1<<DEPTH_LOG2)-1];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          stallRun = 0;
    logic [31:0] lastRdata = '0;

    data_mem_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_byte_en(req_byte_en),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .stall      (stall)
`ifdef DATA_MEM_ALIGN_CHECK_EN
        ,
        .resp_misaligned(resp_misaligned)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference alignment rule: legal (lane pattern, low address) pairs only.
    function automatic logic misModel(input logic w, input logic [31:0] a, input logic [3:0] be);
        logic [1:0] lo;
        lo = a[1:0];
`ifdef DATA_MEM_ALIGN_CHECK_EN
        if (!w) return lo != 2'd0;
        if (be == 4'b1111) return lo != 2'd0;
        if (be == 4'b0011 || be == 4'b1100) return lo[0];
        if (be == (4'b0001 << lo)) return 1'b0;
        return 1'b1;
`else
        return 1'b0 & w & lo[0] & be[0];
`endif
    endfunction

    // Monitor: checks every response against the scoreboard and response-data hold otherwise.
    always @(negedge clock) begin
        expT e;
        if (reset) begin
            stallRun  = 0;
            lastRdata = '0;
        end else begin
            if (stall) stallRun++;
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp actual=resp_valid expected=no response (cycle %0d)", cyc);
                    lastRdata = resp_rdata;
                end else begin
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_latency", cyc, e.cyc);
                    check("stall_cycles", stallRun, WAIT_CYCLES + 2);
                    check("stall_in_done", {31'd0, stall}, 32'd0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
                    check("resp_misaligned", {31'd0, resp_misaligned}, {31'd0, e.mis});
`endif
                    lastRdata = e.rdata;
                end
                stallRun = 0;
            end else begin
                check("resp_rdata_hold", resp_rdata, lastRdata);
            end
        end
    end

    task automatic doReq(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit abandon);
        int   guard;
        int   idx;
        logic mis;
        expT  e;
        guard = 0;
        @(posedge clock); #1;
        req_valid   = 1'b1;
        req_write   = w;
        req_addr    = a;
        req_wdata   = d;
        req_byte_en = be;
        while (!req_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout actual=0 expected=1 (cycle %0d)", cyc);
            req_valid = 1'b0;
            return;
        end
        idx = int'(a[DEPTH_LOG2+1:2]);
        mis = misModel(w, a, be);
        if (!abandon) begin
            if (w) begin
                if (!mis) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                    end
                end
                e.rdata = '0;
            end else begin
                e.rdata = mis ? 32'd0 : model[idx];
            end
            e.mis = mis;
            e.cyc = cyc + WAIT_CYCLES + 2;
            sb.push_back(e);
        end
        @(posedge clock); #1;
        req_valid   = 1'b0;
        req_write   = 1'($urandom);
        req_addr    = $urandom;
        req_wdata   = $urandom;
        req_byte_en = 4'($urandom);
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        check("reset_resp_misaligned", {31'd0, resp_misaligned}, 32'd0);
`endif

        for (int i = 0; i < (1 << DEPTH_LOG2); i++) begin
            doReq(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);
        end

        doReq(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        doReq(1'b0, 32'h10, $urandom, 4'h0, 1'b0);
        doReq(1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b0);
        doReq(1'b0, 32'h10, $urandom, 4'h0, 1'b0);
        doReq(1'b1, 32'h404, 32'h12345678, 4'hF, 1'b0);
        doReq(1'b0, 32'h004, $urandom, 4'h0, 1'b0);
        doReq(1'b1, 32'h20, 32'h0000000F, 4'b0000, 1'b0);
        doReq(1'b0, 32'h20, $urandom, 4'h0, 1'b0);

        doReq(1'b1, 32'h20, 32'h00000055, 4'hF, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("post_reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("post_reset_resp_rdata", resp_rdata, 32'd0);
        doReq(1'b0, 32'h20, $urandom, 4'h0, 1'b0);

`ifdef DATA_MEM_ALIGN_CHECK_EN
        doReq(1'b0, 32'h22, $urandom, 4'h0, 1'b0);
        doReq(1'b0, 32'h20, $urandom, 4'h0, 1'b0);
        doReq(1'b1, 32'h21, 32'hCAFEF00D, 4'hF, 1'b0);
        doReq(1'b1, 32'h22, 32'h0000BB00, 4'b1100, 1'b0);
        doReq(1'b0, 32'h20, $urandom, 4'h0, 1'b0);
`endif

        repeat (300) begin
            logic [3:0] be;
            repeat ($urandom_range(0, 2)) @(posedge clock);
            be = 4'($urandom);
            doReq(1'($urandom), $urandom, $urandom, be, 1'b0);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 30) begin
            @(posedge clock);
            guard++;
        end
        @(negedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
